dma_priority_arbiter: RTL
=========================

Name: dma_priority_arbiter

Overview:
- Resolves the four DMA channel requests (hardware DREQ plus software request register) into a single one-hot valid request for the timing-control FSM.
- Drives the DACK pins and locks the grant for the whole service.
- Applies fixed or rotating priority from the command register.
- Sits between the pins/register file and the timing-control FSM; it is the scheduler that shares the one transfer datapath among channels 0-3.

Parameters:
- NUM_CH, 4, number of channels (fixed at 4 for 8237A compatibility; other values unsupported).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- DREQ  in  4  channel request pins, polarity per dreqSenseLow
- dreqSenseLow  in  1  commandReg[6]: 1 = DREQ active low
- dackSenseHigh  in  1  commandReg[7]: 1 = DACK active high
- rotatingPriority  in  1  commandReg[4]: 1 = rotating, 0 = fixed
- controllerDisable  in  1  commandReg[2]: blocks new grants
- maskReg  in  4  per-channel mask, 1 = masked
- softReq  in  4  request register bits (not maskable)
- idleCycle  in  1  timing control in SI
- activeCycle  in  1  timing control in S1 (service begins)
- serviceDone  in  1  one-cycle pulse: S4 complete or EOP accepted
- VALID_DREQ  out  4  one-hot request to timing control
- DACK  out  4  acknowledge pins, pin level
- grantChan  out  2  channel currently granted
- grantValid  out  1  a grant is held (GRANT or SERVICE)
- softReqClr  out  4  one-cycle pulse clearing the serviced softReq bit

Behaviour:
- Reset (async, RESET_N=0):
  - state=ARB_IDLE, VALID_DREQ=0, grantChan=0, grantValid=0, softReqClr=0.
  - Internal dackOneHot=0, so DACK={4{~dackSenseHigh}} (all inactive).
  - lastServ=3, so channel 0 is highest priority.
  - DREQ sample register=0.
- Request conditioning:
  - hwReq is registered each CLK: DREQ ^ {4{dreqSenseLow}}.
  - pending = (hwReq & ~maskReg) | softReq.
- Priority:
  - Fixed mode: channel 0 > 1 > 2 > 3.
  - Rotating mode: highest = (lastServ+1) mod 4, increasing mod 4 from there. Pointer arithmetic is 2-bit wrap.
  - Switching mode mid-service affects only the next arbitration.
- States:
  - ARB_IDLE:
    - If idleCycle && !controllerDisable && |pending: latch the winner into grantChan and go to ARB_GRANT.
    - Otherwise stay.
  - ARB_GRANT:
    - VALID_DREQ = onehot(grantChan), grantValid=1.
    - If pending[grantChan] drops before activeCycle: go to ARB_IDLE, no pointer update.
    - If activeCycle: go to ARB_SERVICE.
    - If serviceDone (EOP) arrives: go to ARB_IDLE, no pointer update.
  - ARB_SERVICE:
    - VALID_DREQ held, dackOneHot = onehot(grantChan).
    - Grant is locked: no preemption by higher-priority requests, and mask changes are ignored until done.
    - On serviceDone: go to ARB_RELEASE.
  - ARB_RELEASE (exactly 1 cycle):
    - dackOneHot=0, VALID_DREQ=0.
    - softReqClr[grantChan]=1 if softReq[grantChan].
    - lastServ=grantChan when rotatingPriority.
    - Go to ARB_IDLE.
- DACK = dackOneHot ^ {4{~dackSenseHigh}}, combinational from a register (glitch-free).
- Latency:
  - DREQ pin to VALID_DREQ: 2 CLK (sample + grant), given idleCycle.
  - serviceDone to next possible VALID_DREQ: 3 CLK (RELEASE, IDLE decision, GRANT).
- Simultaneous events:
  - Ties are resolved purely by the priority order.
  - controllerDisable asserted during GRANT or SERVICE: the current service completes; the block is blocked once back in IDLE.
  - Masking the granted channel during GRANT withdraws the grant (it counts as a pending drop).
- Invariants: VALID_DREQ and dackOneHot are always zero or one-hot; grantValid=1 iff state is ARB_GRANT or ARB_SERVICE.

Decomposition:
- DmaPackage holds:
  - arb_state_t (ARB_IDLE, ARB_GRANT, ARB_SERVICE, ARB_RELEASE; one-hot encoded, as the timing FSM).
  - chan_t (logic [1:0]).
  - NUM_CH constant.
  - onehot4 function.
- Sub-module dma_priority_encoder: combinational.
  - Inputs: pending[3:0], lastServ, rotatingPriority.
  - Outputs: winner[1:0], anyReq.

Test Plan:
- Fixed priority, DREQ=4'b1010 active high, mask=0, idleCycle=1 -> VALID_DREQ=4'b0010 two cycles after DREQ, grantChan=1; after activeCycle, DACK (active low) = 4'b1101.
- Rotating, four successive services with all DREQ held -> grant order 0,1,2,3,0; lastServ wraps 3->0.
- maskReg=4'b0001 with DREQ0 and DREQ2 asserted, plus softReq[0]=1 -> channel 0 still granted (software request unmaskable); softReqClr=4'b0001 pulse in ARB_RELEASE.
- DREQ3 withdrawn during ARB_GRANT before activeCycle -> return to ARB_IDLE, VALID_DREQ=0, lastServ unchanged.
- Channel 2 in service, DREQ0 asserted -> no preemption; channel 0 granted 3 cycles after serviceDone.
- RESET_N pulsed low during ARB_SERVICE with dackSenseHigh=1 and dreqSenseLow=1 -> DACK=0, VALID_DREQ=0 immediately (async); channel 0 highest priority after release.

Source files
------------

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types for the DMA channel arbiter: channel index, arbiter state encoding
// and the one-hot channel decode helper.
package dma_priority_arbiter_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] chan_t;

  // One-hot encoded to match the timing-control FSM
  typedef enum logic [3:0] {
    ARB_IDLE    = 4'b0001,
    ARB_GRANT   = 4'b0010,
    ARB_SERVICE = 4'b0100,
    ARB_RELEASE = 4'b1000
  } arb_state_t;

  function automatic logic [NUM_CH-1:0] onehot4(input chan_t ch);
    onehot4 = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational priority resolver: fixed 0>1>2>3, or rotating starting one past
// the last serviced channel with 2-bit wrap.
module dma_priority_encoder
  import dma_priority_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  chan_t             lastServ,
  input  logic              rotatingPriority,
  output chan_t             winner,
  output logic              anyReq
);

  chan_t startChan;
  chan_t idx;
  logic  found;

  // Scan channels in priority order from startChan, first pending one wins
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    if (rotatingPriority) begin
      startChan = lastServ + 2'd1;
    end else begin
      startChan = 2'd0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      idx = startChan + chan_t'(i);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
    anyReq = found;
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: conditions DREQ/soft requests, picks a winner, holds the
// grant through the whole service and drives the DACK pins from a register.
module dma_priority_arbiter
  import dma_priority_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
  input  logic              rotatingPriority,
  input  logic              controllerDisable,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] softReq,
  input  logic              idleCycle,
  input  logic              activeCycle,
  input  logic              serviceDone,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic [NUM_CH-1:0] DACK,
  output chan_t             grantChan,
  output logic              grantValid,
  output logic [NUM_CH-1:0] softReqClr
);

  arb_state_t        state;
  arb_state_t        nextState;
  chan_t             nextGrantChan;
  chan_t             lastServ;
  chan_t             winner;
  logic              anyReq;
  logic [NUM_CH-1:0] hwReq;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] dackOneHot;
  logic [NUM_CH-1:0] nextValid;
  logic [NUM_CH-1:0] nextDack;
  logic [NUM_CH-1:0] nextSoftClr;
  logic              nextGrantValid;

  // Software requests bypass the mask
  assign pending = (hwReq & ~maskReg) | softReq;
  assign DACK    = dackOneHot ^ {NUM_CH{~dackSenseHigh}};

  dma_priority_encoder uEncoder (
    .pending          (pending),
    .lastServ         (lastServ),
    .rotatingPriority (rotatingPriority),
    .winner           (winner),
    .anyReq           (anyReq)
  );

  // Next-state decode; outputs are derived from the next state so they can be registered
  always_comb begin
    nextState     = state;
    nextGrantChan = grantChan;
    case (state)
      ARB_IDLE: begin
        if (idleCycle && !controllerDisable && anyReq) begin
          nextState     = ARB_GRANT;
          nextGrantChan = winner;
        end else begin
          nextState = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (serviceDone || !pending[grantChan]) begin
          nextState = ARB_IDLE;
        end else if (activeCycle) begin
          nextState = ARB_SERVICE;
        end else begin
          nextState = ARB_GRANT;
        end
      end
      ARB_SERVICE: begin
        if (serviceDone) begin
          nextState = ARB_RELEASE;
        end else begin
          nextState = ARB_SERVICE;
        end
      end
      ARB_RELEASE: nextState = ARB_IDLE;
      default:     nextState = ARB_IDLE;
    endcase

    nextGrantValid = (nextState == ARB_GRANT) || (nextState == ARB_SERVICE);
    if (nextGrantValid) begin
      nextValid = onehot4(nextGrantChan);
    end else begin
      nextValid = 4'b0000;
    end
    if (nextState == ARB_SERVICE) begin
      nextDack = onehot4(nextGrantChan);
    end else begin
      nextDack = 4'b0000;
    end
    if ((nextState == ARB_RELEASE) && softReq[grantChan]) begin
      nextSoftClr = onehot4(grantChan);
    end else begin
      nextSoftClr = 4'b0000;
    end
  end

  // State, grant and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ARB_IDLE;
      grantChan  <= 2'd0;
      grantValid <= 1'b0;
      VALID_DREQ <= 4'b0000;
      dackOneHot <= 4'b0000;
      softReqClr <= 4'b0000;
      hwReq      <= 4'b0000;
      lastServ   <= 2'd3;
    end else begin
      state      <= nextState;
      grantChan  <= nextGrantChan;
      grantValid <= nextGrantValid;
      VALID_DREQ <= nextValid;
      dackOneHot <= nextDack;
      softReqClr <= nextSoftClr;
      hwReq      <= DREQ ^ {NUM_CH{dreqSenseLow}};
      if ((state == ARB_RELEASE) && rotatingPriority) begin
        lastServ <= grantChan;
      end
    end
  end

endmodule
